button_event_controller: RTL and testbench

BUTTON_EVENT_CONTROLLER -- requirements
Module: button_event_controller

---
 rtl/button_pkg.sv | 24 ++
 rtl/btn_event_fsm.sv | 143 ++++++++++++++
 rtl/button_event_controller.sv | 62 ++++++
 tb/tb_button_event_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
//------------------------------------------------------------------------------
// Module  : button_pkg
// Purpose : Shared FSM encoding and default constants for the button controller.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  localparam int c_N_BTN        = 4;
  localparam int c_TICK_BITS    = 20;
  localparam int c_STABLE_TICKS = 2;
  localparam int c_HOLD_TICKS   = 50;
  localparam int c_REPEAT_TICKS = 10;

endpackage

`default_nettype wire

// File: rtl/btn_event_fsm.sv
//------------------------------------------------------------------------------
// Module  : btn_event_fsm
// Purpose : One button: synchronizer, debounce count, press/hold/repeat FSM.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_event_fsm
  import button_pkg::*;
#(
  parameter int STABLE_TICKS = c_STABLE_TICKS,
  parameter int HOLD_TICKS   = c_HOLD_TICKS,
  parameter int REPEAT_TICKS = c_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [3:0] c_STABLE = 4'(STABLE_TICKS);
  localparam logic [7:0] c_HOLD   = 8'(HOLD_TICKS);
  localparam logic [7:0] c_REPEAT = 8'(REPEAT_TICKS);

  logic       r_sync1, r_sync2;
  logic [3:0] r_stab_cnt, w_stab_cnt_nxt, w_stab_inc;
  logic       r_level, w_level_nxt;
  logic       w_rise, w_fall;
  btn_state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic       r_press, r_release, r_repeat;
  logic       w_press, w_release, w_repeat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_stab_cnt <= 4'd0;
      r_level    <= 1'b0;
      r_cnt      <= 8'd0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_cnt_nxt;
      r_level    <= w_level_nxt;
      r_cnt      <= w_cnt_nxt;
      r_press    <= w_press;
      r_release  <= w_release;
      r_repeat   <= w_repeat;
    end
  end

  always_comb begin
    w_stab_inc     = r_stab_cnt + 4'd1;
    w_cnt_inc      = r_cnt + 8'd1;
    w_stab_cnt_nxt = r_stab_cnt;
    w_level_nxt    = r_level;
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_press        = 1'b0;
    w_release      = 1'b0;
    w_repeat       = 1'b0;
    w_rise         = 1'b0;
    w_fall         = 1'b0;
    if (tick) begin
      if (r_sync2 != r_level) begin
        if (w_stab_inc == c_STABLE) begin
          w_level_nxt    = ~r_level;
          w_stab_cnt_nxt = 4'd0;
        end else begin
          w_stab_cnt_nxt = w_stab_inc;
        end
      end else begin
        w_stab_cnt_nxt = 4'd0;
      end
      w_rise = w_level_nxt & ~r_level;
      w_fall = ~w_level_nxt & r_level;
      // A falling level wins over a repeat that would land on the same tick.
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = 8'd0;
            w_press     = 1'b1;
          end
        end
        HELD: begin
          if (w_fall) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
            w_release   = 1'b1;
          end else if (w_cnt_inc == c_HOLD) begin
            w_state_nxt = REPEAT;
            w_cnt_nxt   = 8'd0;
            w_repeat    = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        REPEAT: begin
          if (w_fall) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
            w_release   = 1'b1;
          end else if (w_cnt_inc == c_REPEAT) begin
            w_cnt_nxt = 8'd0;
            w_repeat  = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  assign level         = r_level;
  assign press_pulse   = r_press   & en;
  assign release_pulse = r_release & en;
  assign repeat_pulse  = r_repeat  & en;

endmodule

`default_nettype wire

// File: rtl/button_event_controller.sv
//------------------------------------------------------------------------------
// Module  : button_event_controller
// Purpose : Shared sample-tick prescaler driving N_BTN debounced button FSMs.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module button_event_controller
  import button_pkg::*;
#(
  parameter int N_BTN        = c_N_BTN,
  parameter int TICK_BITS    = c_TICK_BITS,
  parameter int STABLE_TICKS = c_STABLE_TICKS,
  parameter int HOLD_TICKS   = c_HOLD_TICKS,
  parameter int REPEAT_TICKS = c_REPEAT_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] raw_btn,
  input  logic             en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             tick
);

  logic [TICK_BITS-1:0] r_presc;
  logic                 w_tick;

  assign w_tick = (r_presc == {TICK_BITS{1'b1}}) && en;
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= r_presc + TICK_BITS'(1);
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_event_fsm #(
      .STABLE_TICKS (STABLE_TICKS),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_btn (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .tick          (w_tick),
      .raw           (raw_btn[gi]),
      .level         (level[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .repeat_pulse  (repeat_pulse[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_event_controller.sv
//------------------------------------------------------------------------------
// Module  : tb_button_event_controller
// Purpose : Directed self-checking bench for button_event_controller.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_event_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_btn;
  logic       en;
  logic [3:0] level, press_pulse, release_pulse, repeat_pulse;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  button_event_controller #(
    .N_BTN        (4),
    .TICK_BITS    (3),
    .STABLE_TICKS (2),
    .HOLD_TICKS   (3),
    .REPEAT_TICKS (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_btn       (raw_btn),
    .en            (en),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .tick          (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance past the next tick edge; outputs then reflect that tick.
  task automatic next_tick();
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tick) begin
        step();
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_outs(input string tag, input logic [3:0] lv, input logic [3:0] pr,
                             input logic [3:0] rl, input logic [3:0] rp);
    check({tag, "_level"},   {28'd0, level},         {28'd0, lv});
    check({tag, "_press"},   {28'd0, press_pulse},   {28'd0, pr});
    check({tag, "_release"}, {28'd0, release_pulse}, {28'd0, rl});
    check({tag, "_repeat"},  {28'd0, repeat_pulse},  {28'd0, rp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       any;
    logic [3:0] exp_rp;

    reset   = 1'b1;
    en      = 1'b1;
    raw_btn = 4'b0000;
    step(); step(); step();
    expect_outs("reset", 4'b0, 4'b0, 4'b0, 4'b0);
    check("reset_tick", {31'd0, tick}, 32'd0);

    // Cycle c after release has prescaler c-1; tick when it reaches 7.
    reset = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check($sformatf("tick_c%0d", c), {31'd0, tick}, {31'd0, (c % 8) == 0});
      step();
    end

    step(); step(); step();
    en  = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any |= tick;
      step();
    end
    en = 1'b1;
    check("en_freeze_no_tick", {31'd0, any}, 32'd0);
    step(); step(); step(); step();
    check("en_resume_tick", {31'd0, tick}, 32'd1);
    step();

    raw_btn[0] = 1'b1;
    next_tick();
    expect_outs("b0_t1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    next_tick();
    expect_outs("b0_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step();
    expect_outs("b0_press_width", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    raw_btn[0] = 1'b0;
    next_tick();
    expect_outs("b0_rel_t1", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    next_tick();
    expect_outs("b0_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step();
    expect_outs("b0_release_width", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Bounce phase chosen so the five tick samples read 1,0,0,0,1.
    next_tick();
    any = 1'b0;
    for (int k = 0; k < 40; k++) begin
      raw_btn[1] = (((k + 6) / 5) % 2) == 0;
      any |= (|press_pulse) | (|release_pulse) | (|repeat_pulse) | (|level);
      step();
    end
    raw_btn[1] = 1'b0;
    next_tick();
    next_tick();
    check("bounce_no_events", {31'd0, any}, 32'd0);
    expect_outs("bounce_end", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    raw_btn[2] = 1'b1;
    next_tick();
    expect_outs("b2_t1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    next_tick();
    expect_outs("b2_press", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    for (int t = 1; t <= 11; t++) begin
      next_tick();
      exp_rp = (t >= 3 && (t % 2) == 1 && t != 11) ? 4'b0100 : 4'b0000;
      expect_outs($sformatf("b2_T%0d", t), (t < 11) ? 4'b0100 : 4'b0000, 4'b0000,
                  (t == 11) ? 4'b0100 : 4'b0000, exp_rp);
      if (t == 3) begin
        step();
        check("b2_repeat_width", {28'd0, repeat_pulse}, 32'd0);
      end
      if (t == 9) raw_btn[2] = 1'b0;
    end

    raw_btn = 4'b1001;
    next_tick();
    expect_outs("sim_t1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    next_tick();
    expect_outs("sim_press", 4'b1001, 4'b1001, 4'b0000, 4'b0000);
    raw_btn = 4'b0000;
    next_tick();
    expect_outs("sim_rel_t1", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    next_tick();
    expect_outs("sim_release", 4'b0000, 4'b0000, 4'b1001, 4'b0000);

    raw_btn[3] = 1'b1;
    next_tick();
    next_tick();
    expect_outs("b3_press", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    next_tick();
    next_tick();
    next_tick();
    expect_outs("b3_repeat", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    step(); step();
    reset = 1'b1;
    step();
    expect_outs("rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("rst_mid_tick", {31'd0, tick}, 32'd0);
    step();
    reset = 1'b0;
    expect_outs("rst_end", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    next_tick();
    expect_outs("rst_redetect_t1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    next_tick();
    expect_outs("rst_redetect_press", 4'b1000, 4'b1000, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
